// File: rtl/acq_fifo_writer.sv
// acq_fifo_writer: gathers one sample from each of the X, Y, current and Z
// sources and writes all four sample FIFOs in the same cycle, with
// decimation, partial-set timeout and overflow accounting.
// Optional feature: define ACQ_TIMESTAMP_EN to pack a free-running cycle
// timestamp into the upper TS_WIDTH bits of every word. Without it, each
// sample is sign-extended to the full FIFO_LENGTH bits.
module acq_fifo_writer #(
   parameter int unsigned FIFO_LENGTH    = 64,
   parameter int unsigned SAMPLE_WIDTH   = 32,
   parameter int unsigned TS_WIDTH       = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    acq_enable,
   input  logic [15:0]             decim_ratio,
   input  logic                    clear_status,
   input  logic                    x_valid,
   input  logic                    y_valid,
   input  logic                    i_valid,
   input  logic                    z_valid,
   input  logic [SAMPLE_WIDTH-1:0] x_data,
   input  logic [SAMPLE_WIDTH-1:0] y_data,
   input  logic [SAMPLE_WIDTH-1:0] i_data,
   input  logic [SAMPLE_WIDTH-1:0] z_data,
   output logic                    x_wrreq,
   output logic                    y_wrreq,
   output logic                    i_wrreq,
   output logic                    z_wrreq,
   output logic [FIFO_LENGTH-1:0]  x_wrdata,
   output logic [FIFO_LENGTH-1:0]  y_wrdata,
   output logic [FIFO_LENGTH-1:0]  i_wrdata,
   output logic [FIFO_LENGTH-1:0]  z_wrdata,
   input  logic                    x_wrfull,
   input  logic                    y_wrfull,
   input  logic                    i_wrfull,
   input  logic                    z_wrfull,
   output logic [CNT_WIDTH-1:0]    overflow_count,
   output logic [CNT_WIDTH-1:0]    misalign_count,
   output logic                    overflow_sticky
);

   localparam int unsigned NSRC  = 4;
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`ifdef ACQ_TIMESTAMP_EN
   localparam int unsigned EXT_W = FIFO_LENGTH - TS_WIDTH;
`else
   localparam int unsigned EXT_W = FIFO_LENGTH;
`endif

   // Source vectors, index order {z, i, y, x}
   logic [NSRC-1:0]                    valid_w;
   logic [NSRC-1:0]                    full_w;
   logic [NSRC-1:0][SAMPLE_WIDTH-1:0]  data_w;
   logic [NSRC-1:0][SAMPLE_WIDTH-1:0]  samp_w;
   logic [NSRC-1:0][FIFO_LENGTH-1:0]   word_w;

   logic [NSRC-1:0]                    have_q, have_d;
   logic [NSRC-1:0][SAMPLE_WIDTH-1:0]  hold_q, hold_d;
   logic [NSRC-1:0][FIFO_LENGTH-1:0]   wrdata_q, wrdata_d;
   logic                               wrreq_q, wrreq_d;
   logic [TMO_W-1:0]                   tmo_q, tmo_d;
   logic [15:0]                        dec_q, dec_d;
   logic [CNT_WIDTH-1:0]               ovf_q, ovf_d;
   logic [CNT_WIDTH-1:0]               mis_q, mis_d;
   logic                               sticky_q, sticky_d;

   logic [15:0]                        dec_last;
   logic                               complete;
   logic                               timeout;
   logic                               selected;
   logic                               any_full;
   logic                               ovf_inc;

   assign valid_w = {z_valid, i_valid, y_valid, x_valid};
   assign full_w  = {z_wrfull, i_wrfull, y_wrfull, x_wrfull};
   assign data_w  = {z_data, i_data, y_data, x_data};

`ifdef ACQ_TIMESTAMP_EN
   logic [TS_WIDTH-1:0] ts_q, ts_d;

   assign ts_d = ts_q + TS_WIDTH'(1);

   // Free-running cycle timestamp, wraps modulo 2^TS_WIDTH
   always_ff @(posedge clk) begin
      if (reset) ts_q <= '0;
      else       ts_q <= ts_d;
   end
`endif

   // Effective sample per source (same-cycle strobe wins) and packed word
   always_comb begin
      samp_w = '0;
      word_w = '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         samp_w[i] = valid_w[i] ? data_w[i] : hold_q[i];
`ifdef ACQ_TIMESTAMP_EN
         word_w[i] = {ts_q, EXT_W'(signed'(samp_w[i]))};
`else
         word_w[i] = EXT_W'(signed'(samp_w[i]));
`endif
      end
   end

   // Set completion, timeout, decimation selection and next-state logic
   always_comb begin
      complete = acq_enable & (&(have_q | valid_w));
      timeout  = acq_enable & (|have_q) & ~complete &
                 (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
      dec_last = (decim_ratio > 16'd1) ? (decim_ratio - 16'd1) : '0;
      selected = (dec_q == '0);
      any_full = |full_w;
      ovf_inc  = complete & selected & any_full;

      have_d   = have_q;
      hold_d   = hold_q;
      tmo_d    = tmo_q;
      dec_d    = dec_q;

      if (acq_enable) begin
         for (int unsigned i = 0; i < NSRC; i++) begin
            if (valid_w[i]) hold_d[i] = data_w[i];
         end
      end

      // Completion and timeout both swallow same-cycle strobes; nothing
      // carries over into the next set from those cycles.
      if (!acq_enable) begin
         have_d = '0;
         tmo_d  = '0;
         dec_d  = '0;
      end else if (complete) begin
         have_d = '0;
         tmo_d  = '0;
         dec_d  = (dec_q >= dec_last) ? '0 : (dec_q + 16'd1);
      end else if (timeout) begin
         have_d = '0;
         tmo_d  = '0;
      end else begin
         have_d = have_q | valid_w;
         tmo_d  = (|have_q) ? (tmo_q + TMO_W'(1)) : '0;
      end

      wrreq_d  = complete & selected & ~any_full;
      wrdata_d = wrreq_d ? word_w : wrdata_q;

      ovf_d    = ovf_q;
      mis_d    = mis_q;
      sticky_d = sticky_q;
      if (clear_status) begin
         ovf_d    = '0;
         mis_d    = '0;
         sticky_d = 1'b0;
      end else begin
         if (ovf_inc && !(&ovf_q)) ovf_d = ovf_q + CNT_WIDTH'(1);
         if (timeout && !(&mis_q)) mis_d = mis_q + CNT_WIDTH'(1);
         if (ovf_inc)              sticky_d = 1'b1;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         have_q   <= '0;
         hold_q   <= '0;
         wrdata_q <= '0;
         wrreq_q  <= 1'b0;
         tmo_q    <= '0;
         dec_q    <= '0;
         ovf_q    <= '0;
         mis_q    <= '0;
         sticky_q <= 1'b0;
      end else begin
         have_q   <= have_d;
         hold_q   <= hold_d;
         wrdata_q <= wrdata_d;
         wrreq_q  <= wrreq_d;
         tmo_q    <= tmo_d;
         dec_q    <= dec_d;
         ovf_q    <= ovf_d;
         mis_q    <= mis_d;
         sticky_q <= sticky_d;
      end
   end

   // A write registered for this cycle is dropped if reset is asserted now
   assign x_wrreq = wrreq_q & ~reset;
   assign y_wrreq = wrreq_q & ~reset;
   assign i_wrreq = wrreq_q & ~reset;
   assign z_wrreq = wrreq_q & ~reset;

   assign x_wrdata = wrdata_q[0];
   assign y_wrdata = wrdata_q[1];
   assign i_wrdata = wrdata_q[2];
   assign z_wrdata = wrdata_q[3];

   assign overflow_count  = ovf_q;
   assign misalign_count  = mis_q;
   assign overflow_sticky = sticky_q;

endmodule

// File: tb/tb_acq_fifo_writer.sv
// Directed bench for acq_fifo_writer: table-driven set/decimation vectors
// plus hand sequences for overflow, timeout and reset corner cases.
module tb_acq_fifo_writer;

   localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

   logic        clk;
   logic        reset;
   logic        acq_enable;
   logic [15:0] decim_ratio;
   logic        clear_status;
   logic        x_valid, y_valid, i_valid, z_valid;
   logic [31:0] x_data, y_data, i_data, z_data;
   logic        x_wrreq, y_wrreq, i_wrreq, z_wrreq;
   logic [63:0] x_wrdata, y_wrdata, i_wrdata, z_wrdata;
   logic        x_wrfull, y_wrfull, i_wrfull, z_wrfull;
   logic [15:0] overflow_count, misalign_count;
   logic        overflow_sticky;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [31:0] tb_ts;

   typedef struct {
      logic        en;
      logic [15:0] dec;
      logic [3:0]  v;      // {z, i, y, x}
      logic [31:0] dx, dy, di, dz;
      logic [3:0]  full;   // {z, i, y, x}
      logic        wr;
      logic [31:0] ex, ey, ei, ez;
   } vec_t;

   vec_t tbl[$];

   acq_fifo_writer #(
      .FIFO_LENGTH   (64),
      .SAMPLE_WIDTH  (32),
      .TS_WIDTH      (32),
      .TIMEOUT_CYCLES(16),
      .CNT_WIDTH     (16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .acq_enable     (acq_enable),
      .decim_ratio    (decim_ratio),
      .clear_status   (clear_status),
      .x_valid        (x_valid),
      .y_valid        (y_valid),
      .i_valid        (i_valid),
      .z_valid        (z_valid),
      .x_data         (x_data),
      .y_data         (y_data),
      .i_data         (i_data),
      .z_data         (z_data),
      .x_wrreq        (x_wrreq),
      .y_wrreq        (y_wrreq),
      .i_wrreq        (i_wrreq),
      .z_wrreq        (z_wrreq),
      .x_wrdata       (x_wrdata),
      .y_wrdata       (y_wrdata),
      .i_wrdata       (i_wrdata),
      .z_wrdata       (z_wrdata),
      .x_wrfull       (x_wrfull),
      .y_wrfull       (y_wrfull),
      .i_wrfull       (i_wrfull),
      .z_wrfull       (z_wrfull),
      .overflow_count (overflow_count),
      .misalign_count (misalign_count),
      .overflow_sticky(overflow_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic en, input logic [15:0] dec,
                               input logic [3:0] v,
                               input logic [31:0] dx, input logic [31:0] dy,
                               input logic [31:0] di, input logic [31:0] dz,
                               input logic [3:0] full, input logic wr,
                               input logic [31:0] ex, input logic [31:0] ey,
                               input logic [31:0] ei, input logic [31:0] ez);
      vec_t t;
      t.en = en; t.dec = dec; t.v = v;
      t.dx = dx; t.dy = dy; t.di = di; t.dz = dz;
      t.full = full; t.wr = wr;
      t.ex = ex; t.ey = ey; t.ei = ei; t.ez = ez;
      return t;
   endfunction

   function automatic vec_t idle(input logic en, input logic [15:0] dec);
      return mk(en, dec, 4'b0000, JUNK, JUNK, JUNK, JUNK, 4'b0000, 1'b0, '0, '0, '0, '0);
   endfunction

   function automatic logic [63:0] exp_word(input logic [31:0] s, input logic [31:0] ts);
`ifdef ACQ_TIMESTAMP_EN
      return {ts, s};
`else
      return {{32{s[31]}}, s};
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      if (reset) tb_ts = '0;
      else       tb_ts = tb_ts + 32'd1;
      #1;
   endtask

   task automatic apply(input vec_t t, input string tag);
      logic [31:0] ts_cap;
      acq_enable  = t.en;
      decim_ratio = t.dec;
      {z_valid, i_valid, y_valid, x_valid} = t.v;
      x_data = t.dx; y_data = t.dy; i_data = t.di; z_data = t.dz;
      {z_wrfull, i_wrfull, y_wrfull, x_wrfull} = t.full;
      ts_cap = tb_ts;
      step();
      chk($sformatf("%s_wrreq", tag), 64'({z_wrreq, i_wrreq, y_wrreq, x_wrreq}), 64'({4{t.wr}}));
      if (t.wr) begin
         chk($sformatf("%s_xword", tag), x_wrdata, exp_word(t.ex, ts_cap));
         chk($sformatf("%s_yword", tag), y_wrdata, exp_word(t.ey, ts_cap));
         chk($sformatf("%s_iword", tag), i_wrdata, exp_word(t.ei, ts_cap));
         chk($sformatf("%s_zword", tag), z_wrdata, exp_word(t.ez, ts_cap));
      end
   endtask

   initial begin
      reset = 1'b1; acq_enable = 1'b0; decim_ratio = 16'd1; clear_status = 1'b0;
      x_valid = 1'b0; y_valid = 1'b0; i_valid = 1'b0; z_valid = 1'b0;
      x_data = '0; y_data = '0; i_data = '0; z_data = '0;
      x_wrfull = 1'b0; y_wrfull = 1'b0; i_wrfull = 1'b0; z_wrfull = 1'b0;
      tb_ts = '0;

      // Single set: x, then y and i together, then z two idle cycles later
      tbl.push_back(idle(1'b1, 16'd1));
      tbl.push_back(mk(1'b1, 16'd1, 4'b0001, 32'd1, JUNK, JUNK, JUNK, 4'b0000, 1'b0, '0, '0, '0, '0));
      tbl.push_back(idle(1'b1, 16'd1));
      tbl.push_back(mk(1'b1, 16'd1, 4'b0110, JUNK, 32'hFFFF_FFFF, 32'h7FFF_FFFF, JUNK, 4'b0000, 1'b0, '0, '0, '0, '0));
      tbl.push_back(idle(1'b1, 16'd1));
      tbl.push_back(idle(1'b1, 16'd1));
      tbl.push_back(mk(1'b1, 16'd1, 4'b1000, JUNK, JUNK, JUNK, 32'd5, 4'b0000, 1'b1,
                       32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5));
      tbl.push_back(idle(1'b1, 16'd1));
      // Strobes while disabled must not set any flag
      tbl.push_back(idle(1'b0, 16'd3));
      tbl.push_back(mk(1'b0, 16'd3, 4'b1111, 32'd7, 32'd7, 32'd7, 32'd7, 4'b0000, 1'b0, '0, '0, '0, '0));
      tbl.push_back(idle(1'b1, 16'd3));
      // Decimation by 3 over ten complete sets: sets 1, 4, 7, 10 written
      for (int k = 1; k <= 10; k++) begin
         logic [31:0] a, b, c, d;
         a = 32'(k); b = -32'(k); c = 32'(k) << 8; d = ~32'(k);
         tbl.push_back(mk(1'b1, 16'd3, 4'b1111, a, b, c, d, 4'b0000, (k % 3) == 1, a, b, c, d));
         tbl.push_back(idle(1'b1, 16'd3));
      end
      tbl.push_back(idle(1'b0, 16'd1));
      // Newest wins: x strobes 3 then 9
      tbl.push_back(mk(1'b1, 16'd1, 4'b0001, 32'd3, JUNK, JUNK, JUNK, 4'b0000, 1'b0, '0, '0, '0, '0));
      tbl.push_back(mk(1'b1, 16'd1, 4'b0001, 32'd9, JUNK, JUNK, JUNK, 4'b0000, 1'b0, '0, '0, '0, '0));
      tbl.push_back(mk(1'b1, 16'd1, 4'b1110, JUNK, 32'd20, 32'd21, 32'd22, 4'b0000, 1'b1,
                       32'd9, 32'd20, 32'd21, 32'd22));
      tbl.push_back(idle(1'b1, 16'd1));
      // Re-strobe of a flagged source in the completion cycle is used
      tbl.push_back(mk(1'b1, 16'd1, 4'b0011, 32'd30, 32'd31, JUNK, JUNK, 4'b0000, 1'b0, '0, '0, '0, '0));
      tbl.push_back(mk(1'b1, 16'd1, 4'b1101, 32'd40, JUNK, 32'd42, 32'd43, 4'b0000, 1'b1,
                       32'd40, 32'd31, 32'd42, 32'd43));
      tbl.push_back(idle(1'b1, 16'd1));

      // Reset state
      step();
      step();
      chk("rst_wrreq", 64'({z_wrreq, i_wrreq, y_wrreq, x_wrreq}), 64'd0);
      chk("rst_xdata", x_wrdata, 64'd0);
      chk("rst_ydata", y_wrdata, 64'd0);
      chk("rst_idata", i_wrdata, 64'd0);
      chk("rst_zdata", z_wrdata, 64'd0);
      chk("rst_ovf", 64'(overflow_count), 64'd0);
      chk("rst_mis", 64'(misalign_count), 64'd0);
      chk("rst_sticky", 64'(overflow_sticky), 64'd0);
      reset = 1'b0;

      for (int r = 0; r < tbl.size(); r++) apply(tbl[r], $sformatf("row%0d", r));

      // Overflow: z full during a selected completion
      apply(mk(1'b1, 16'd1, 4'b1111, 32'd1, 32'd2, 32'd3, 32'd4, 4'b1000, 1'b0, '0, '0, '0, '0), "ovf1");
      chk("ovf1_count", 64'(overflow_count), 64'd1);
      chk("ovf1_sticky", 64'(overflow_sticky), 64'd1);
      apply(mk(1'b1, 16'd1, 4'b1111, 32'd1, 32'd2, 32'd3, 32'd4, 4'b0001, 1'b0, '0, '0, '0, '0), "ovf2");
      chk("ovf2_count", 64'(overflow_count), 64'd2);
      clear_status = 1'b1;
      apply(idle(1'b1, 16'd1), "clr");
      clear_status = 1'b0;
      chk("clr_count", 64'(overflow_count), 64'd0);
      chk("clr_sticky", 64'(overflow_sticky), 64'd0);
      // Clear coinciding with an overflow increment: clear wins
      clear_status = 1'b1;
      apply(mk(1'b1, 16'd1, 4'b1111, 32'd1, 32'd2, 32'd3, 32'd4, 4'b0100, 1'b0, '0, '0, '0, '0), "clrovf");
      clear_status = 1'b0;
      chk("clrovf_count", 64'(overflow_count), 64'd0);
      chk("clrovf_sticky", 64'(overflow_sticky), 64'd0);

      // Timeout: only x and y strobe
      apply(mk(1'b1, 16'd1, 4'b0011, 32'd50, 32'd51, JUNK, JUNK, 4'b0000, 1'b0, '0, '0, '0, '0), "tmo_xy");
      for (int k = 0; k < 15; k++) apply(idle(1'b1, 16'd1), $sformatf("tmo_idle%0d", k));
      chk("tmo_before", 64'(misalign_count), 64'd0);
      apply(idle(1'b1, 16'd1), "tmo_last");
      chk("tmo_after", 64'(misalign_count), 64'd1);
      // Flags must be clear: i and z alone do not complete
      apply(mk(1'b1, 16'd1, 4'b1100, JUNK, JUNK, 32'd62, 32'd63, 4'b0000, 1'b0, '0, '0, '0, '0), "tmo_iz");
      apply(mk(1'b1, 16'd1, 4'b0011, 32'd60, 32'd61, JUNK, JUNK, 4'b0000, 1'b1,
               32'd60, 32'd61, 32'd62, 32'd63), "tmo_full");
      chk("tmo_mis_hold", 64'(misalign_count), 64'd1);

      // Reset mid-set discards the partial set
      apply(mk(1'b1, 16'd1, 4'b0111, 32'd70, 32'd71, 32'd72, JUNK, 4'b0000, 1'b0, '0, '0, '0, '0), "rms_xyi");
      reset = 1'b1;
      apply(idle(1'b1, 16'd1), "rms_rst");
      reset = 1'b0;
      apply(mk(1'b1, 16'd1, 4'b1000, JUNK, JUNK, JUNK, 32'd73, 4'b0000, 1'b0, '0, '0, '0, '0), "rms_z");
      apply(idle(1'b1, 16'd1), "rms_idle");

      // Pending write suppressed by reset in the write cycle
      apply(mk(1'b1, 16'd1, 4'b1111, 32'd80, 32'd81, 32'd82, 32'd83, 4'b0000, 1'b1,
               32'd80, 32'd81, 32'd82, 32'd83), "sup_set");
      reset = 1'b1;
      #1;
      chk("sup_wrreq", 64'({z_wrreq, i_wrreq, y_wrreq, x_wrreq}), 64'd0);
      step();
      reset = 1'b0;
      apply(idle(1'b1, 16'd1), "sup_idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
